// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8-bit UART receiver with optional even/odd parity and framing check
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   rx             asynchronous serial line, idle high
//   parity_en      1 = frame carries a parity bit after the data bits
//   parity_type    0 = even, 1 = odd
//   data_out       last received byte (LSB first on the line)
//   data_valid     one-cycle pulse per completed frame
//   parity_error   parity mismatch for the frame flagged by data_valid
//   framing_error  stop bit sampled low for the frame flagged by data_valid
//   busy           high whenever the receiver is not idle
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       parity_type,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID = CW'((CLKS_PER_BIT - 1) / 2);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shift;
    logic rx_m, rx_s, p_en, p_type, p_bit, stop_bit;
    logic at_last;
    assign at_last = cnt == LAST;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shift <= '0;
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            p_en <= 1'b0;
            p_type <= 1'b0;
            p_bit <= 1'b0;
            stop_bit <= 1'b1;
            data_out <= '0;
            data_valid <= 1'b0;
            parity_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            data_valid <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt <= '0;
                    p_en <= parity_en;
                    p_type <= parity_type;
                end
                // mid-bit check of the start bit rejects glitches
                START: if (cnt == MID) begin
                    state <= rx_s ? IDLE : DATA;
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
                DATA: if (at_last) begin
                    shift[idx] <= rx_s;
                    cnt <= '0;
                    idx <= idx + 1'b1;
                    if (idx == 3'd7) state <= p_en ? PARITY : STOP;
                end else cnt <= cnt + 1'b1;
                PARITY: if (at_last) begin
                    p_bit <= rx_s;
                    cnt <= '0;
                    state <= STOP;
                end else cnt <= cnt + 1'b1;
                // sampling at the stop-bit midpoint leaves half a bit to re-arm for the next start
                STOP: if (at_last) begin
                    stop_bit <= rx_s;
                    cnt <= '0;
                    state <= DONE;
                end else cnt <= cnt + 1'b1;
                DONE: begin
                    data_out <= shift;
                    data_valid <= 1'b1;
                    framing_error <= !stop_bit;
                    // odd parity flips the expected bit relative to even
                    parity_error <= p_en & (p_bit ^ (^shift) ^ p_type);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
